// File: rtl/popcount_rr_arbiter.sv
// popcount_rr_arbiter: round-robin shared popcount with one-entry registered output stage
module popcount_rr_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4
) (
  input  logic                         clk_i,
  input  logic                         srst_i,
  input  logic [NUM_REQ*WIDTH-1:0]     req_data_i,
  input  logic [NUM_REQ-1:0]           req_val_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic [$clog2(WIDTH):0]       data_o,
  output logic [$clog2(NUM_REQ)-1:0]   id_o,
  output logic                         data_val_o,
  input  logic                         data_ready_i
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] ptr, gnt;
  logic          found, accept_en, xfer;
  logic [WIDTH-1:0] word;
  logic [CW-1:0] cnt;
  int unsigned   idx;
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr) + 32'(i)) % NUM_REQ;
      if (!found && req_val_i[idx]) begin
        found = 1'b1;
        gnt   = IW'(idx);
      end
    end
  end
  always_comb begin
    word = req_data_i[32'(gnt)*WIDTH +: WIDTH];
    cnt  = '0;
    for (int j = 0; j < WIDTH; j++) cnt = cnt + CW'(word[j]);
  end
  assign accept_en   = !data_val_o || data_ready_i;
  assign xfer        = found && accept_en && !srst_i;
  assign req_ready_o = xfer ? (NUM_REQ'(1) << gnt) : '0;
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      data_o     <= '0;
      id_o       <= '0;
      data_val_o <= 1'b0;
      ptr        <= '0;
    end else if (xfer) begin
      data_o     <= cnt;
      id_o       <= gnt;
      data_val_o <= 1'b1;
      ptr        <= (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
    end else if (data_ready_i) begin
      data_val_o <= 1'b0;
    end
  end
endmodule
